immediate_gen: RTL and testbench
================================

// Module: immediate_gen
// PURPOSE
//   RV32I immediate extractor in the decode stage of the CPU pipeline.
//   - Takes the 32-bit fetched instruction word and decodes the format from the opcode.
//   - Assembles and sign-extends the I/S/B/U/J immediate.
//   - Registers the immediate and its format code on the rising clock edge for the execute stage.
// PARAMETERS
//   XLEN       32  datapath width of data_out; only 32 is supported.
//   RESET_IMM  0   value loaded into data_out on reset.
// PORTS
//   clk       in   1   system clock; all state updates on the rising edge.
//   rst_n     in   1   asynchronous, active-low reset.
//   data_in   in   32  instruction word; opcode is bits [6:0].
//   data_out  out  32  registered, sign-extended immediate.
//   imm_type  out  3   registered format code:
//                      0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm).
// BEHAVIOUR
//   - Reset: rst_n low forces data_out=RESET_IMM and imm_type=0 immediately (no clock needed).
//     Both outputs hold while rst_n stays low.
//   - Release: the first capture is the first rising edge with rst_n high.
//   - Latency: 1 cycle. data_in sampled at edge N appears on data_out/imm_type after edge N.
//     No handshake; a new capture on every edge.
//   - Format decode by opcode = data_in[6:0]:
//     - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> I.
//       imm = {{20{i[31]}}, i[31:20]}.
//     - 0100011 STORE -> S.
//       imm = {{20{i[31]}}, i[31:25], i[11:7]}.
//     - 1100011 BRANCH -> B.
//       imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
//     - 0110111 LUI, 0010111 AUIPC -> U.
//       imm = {i[31:12], 12'b0}.
//     - 1101111 JAL -> J.
//       imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
//     - 1110011 SYSTEM -> I (CSR address sign-extended), unless overridden by the optional feature.
//     - Any other opcode, including 0x00000000 -> data_out=0, imm_type=0.
//   - OP-IMM shifts (funct3 001/101) are treated as plain I-type; the shamt and funct7 bits stay in imm[11:0].
//   - Bit 31 is always the sign source for I/S/B/J. U-type is never sign-extended beyond bit 31.
//   - B and J immediates always have bit 0 = 0.
//   - data_out is combinationally independent of data_in between edges (fully registered).
// CONFIGURATION
//   IMM_ZICSR_EN defined:
//     - SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> imm_type=6.
//     - data_out = {27'b0, i[19:15]} (zero-extended zimm).
//     - Other SYSTEM encodings stay I-type.
//   IMM_ZICSR_EN undefined:
//     - All SYSTEM encodings decode as I-type; imm_type code 6 is never produced.
// TESTING
//   1. Reset with rst_n=0, data_in=0x00000000 -> data_out=0x00000000, imm_type=0.
//      Release rst_n; apply 0x00000004 -> still 0x00000000 (illegal opcode).
//   2. Apply 0xFFF00093 (addi x1,x0,-1) -> data_out=0xFFFFFFFF, imm_type=1 after one edge.
//      Apply 0x00112623 (sw x1,12(x2)) -> data_out=0x0000000C, imm_type=2.
//   3. Apply 0xFE000CE3 (beq x0,x0,-8) -> data_out=0xFFFFFFF8, imm_type=3.
//      Apply 0xFFDFF06F (jal x0,-4) -> data_out=0xFFFFFFFC, imm_type=5.
//   4. Apply 0x123452B7 (lui x5,0x12345) -> data_out=0x12345000, imm_type=4.
//      Output must not change before the clock edge.
//   5. With data_out=0x12345000, drop rst_n mid-cycle -> data_out=0 without a clock edge.
//      Release rst_n -> next edge loads the current data_in's immediate.
//   6. Apply 0x0002D073 (csrrwi x0,0x000,5):
//      - IMM_ZICSR_EN defined -> data_out=0x00000005, imm_type=6.
//      - IMM_ZICSR_EN undefined -> data_out=0x00000000, imm_type=1.

Source files
------------

// File: rtl/immediate_gen.sv
// RV32I decode-stage immediate extractor.
// Decodes the instruction format from the opcode and builds the sign-extended
// I/S/B/U/J immediate. The immediate and its format code are registered for
// the execute stage.
// Optional feature macro: IMM_ZICSR_EN. When it is defined, CSRRWI/CSRRSI/CSRRCI
// produce the zero-extended zimm with format code 6.
module immediate_gen #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_IMM = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      data_in,
   output logic [XLEN-1:0]  data_out,
   output logic [2:0]       imm_type
);

   localparam int unsigned ILEN   = 32;
   localparam int unsigned OPW    = 7;
   localparam int unsigned TYPE_W = 3;

   // Opcodes that carry an immediate
   localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPW-1:0] OP_SYSTEM = 7'b1110011;

   // Format codes presented on imm_type
   localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd0;
   localparam logic [TYPE_W-1:0] TYPE_I    = 3'd1;
   localparam logic [TYPE_W-1:0] TYPE_S    = 3'd2;
   localparam logic [TYPE_W-1:0] TYPE_B    = 3'd3;
   localparam logic [TYPE_W-1:0] TYPE_U    = 3'd4;
   localparam logic [TYPE_W-1:0] TYPE_J    = 3'd5;
`ifdef IMM_ZICSR_EN
   localparam logic [TYPE_W-1:0] TYPE_Z    = 3'd6;
`endif

   logic [OPW-1:0]    opcode;
   logic              sign;
   logic [ILEN-1:0]   imm_i;
   logic [ILEN-1:0]   imm_s;
   logic [ILEN-1:0]   imm_b;
   logic [ILEN-1:0]   imm_u;
   logic [ILEN-1:0]   imm_j;
   logic [ILEN-1:0]   imm_c;
   logic [TYPE_W-1:0] type_c;

   assign opcode = data_in[OPW-1:0];
   assign sign   = data_in[31];

   // Candidate immediates for every format; bit 31 is the sign source
   always_comb begin
      imm_i = {{20{sign}}, data_in[31:20]};
      imm_s = {{20{sign}}, data_in[31:25], data_in[11:7]};
      imm_b = {{19{sign}}, sign, data_in[7], data_in[30:25], data_in[11:8], 1'b0};
      imm_u = {data_in[31:12], 12'b0};
      imm_j = {{11{sign}}, sign, data_in[19:12], data_in[20], data_in[30:21], 1'b0};
   end

   // Select the immediate and format code from the opcode
   always_comb begin
      imm_c  = '0;
      type_c = TYPE_NONE;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: begin
            imm_c  = imm_i;
            type_c = TYPE_I;
         end
         OP_STORE: begin
            imm_c  = imm_s;
            type_c = TYPE_S;
         end
         OP_BRANCH: begin
            imm_c  = imm_b;
            type_c = TYPE_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm_c  = imm_u;
            type_c = TYPE_U;
         end
         OP_JAL: begin
            imm_c  = imm_j;
            type_c = TYPE_J;
         end
         OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
            if (data_in[14]) begin
               imm_c  = {27'b0, data_in[19:15]};
               type_c = TYPE_Z;
            end else begin
               imm_c  = imm_i;
               type_c = TYPE_I;
            end
`else
            imm_c  = imm_i;
            type_c = TYPE_I;
`endif
         end
         default: begin
            imm_c  = '0;
            type_c = TYPE_NONE;
         end
      endcase
   end

   // Output register for the execute stage; reset acts without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= RESET_IMM;
         imm_type <= TYPE_NONE;
      end else begin
         data_out <= XLEN'(imm_c);
         imm_type <= type_c;
      end
   end

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen using an expected-value queue.
// Honours IMM_ZICSR_EN the same way as the design build.
module tb_immediate_gen;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [2:0]  imm_type;

   typedef struct packed {
      logic [31:0] imm;
      logic [2:0]  typ;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   immediate_gen #(.XLEN(32), .RESET_IMM(32'h0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_out (data_out),
      .imm_type (imm_type)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference immediate built with shifts and masks on a signed word
   function automatic exp_t model(input logic [31:0] w);
      logic signed [31:0] sw;
      logic [31:0]        top;
      exp_t               e;
      sw    = w;
      top   = 32'(sw >>> 31);
      e.imm = 32'h0;
      e.typ = 3'd0;
      case (w & 32'h7f)
         32'h13, 32'h03, 32'h67: begin e.imm = 32'(sw >>> 20); e.typ = 3'd1; end
         32'h23: begin e.imm = (32'(sw >>> 25) << 5) | ((w >> 7) & 32'h1f); e.typ = 3'd2; end
         32'h63: begin
            e.imm = (top << 12) | (((w >> 7) & 32'h1) << 11) |
                    (((w >> 25) & 32'h3f) << 5) | (((w >> 8) & 32'hf) << 1);
            e.typ = 3'd3;
         end
         32'h37, 32'h17: begin e.imm = w & 32'hffff_f000; e.typ = 3'd4; end
         32'h6f: begin
            e.imm = (top << 20) | (((w >> 12) & 32'hff) << 12) |
                    (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3ff) << 1);
            e.typ = 3'd5;
         end
         32'h73: begin
`ifdef IMM_ZICSR_EN
            if (((w >> 14) & 32'h1) != 0) begin
               e.imm = (w >> 15) & 32'h1f;
               e.typ = 3'd6;
            end else begin
               e.imm = 32'(sw >>> 20);
               e.typ = 3'd1;
            end
`else
            e.imm = 32'(sw >>> 20);
            e.typ = 3'd1;
`endif
         end
         default: begin e.imm = 32'h0; e.typ = 3'd0; end
      endcase
      return e;
   endfunction

   // Pop the oldest expectation and compare against the registered outputs
   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_val({tag, "_imm"},  data_out, e.imm);
         check_val({tag, "_type"}, 32'(imm_type), 32'(e.typ));
      end
   endtask

   // Drive one word at the falling edge, check it after the next rising edge
   task automatic drive(input logic [31:0] w, input string tag);
      @(negedge clk);
      data_in = w;
      sb.push_back(model(w));
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6f, 7'h73, 7'h33};

   initial begin
      exp_t e;
      logic [31:0] w;
      rst_n   = 1'b1;
      data_in = 32'h0;
      #1 rst_n = 1'b0;
      #1;
      check_val("reset_imm",  data_out, 32'h0);
      check_val("reset_type", 32'(imm_type), 32'd0);

      // Outputs hold through edges while reset is low
      data_in = 32'hFFF00093;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_hold_imm",  data_out, 32'h0);
      check_val("reset_hold_type", 32'(imm_type), 32'd0);

      @(negedge clk);
      data_in = 32'h0;
      rst_n   = 1'b1;

      // Directed vectors with hand-derived results
      drive(32'h00000004, "illegal");
      check_val("illegal_const", data_out, 32'h00000000);
      drive(32'hFFF00093, "addi");
      check_val("addi_const", data_out, 32'hFFFFFFFF);
      drive(32'h00112623, "sw");
      check_val("sw_const", data_out, 32'h0000000C);
      drive(32'hFE000CE3, "beq");
      check_val("beq_const", data_out, 32'hFFFFFFF8);
      drive(32'hFFDFF06F, "jal");
      check_val("jal_const", data_out, 32'hFFFFFFFC);

      // LUI: output must hold the previous value until the edge
      @(negedge clk);
      data_in = 32'h123452B7;
      sb.push_back(model(32'h123452B7));
      #2;
      check_val("hold_before_edge", data_out, 32'hFFFFFFFC);
      @(posedge clk);
      #1;
      pop_check("lui");
      check_val("lui_const", data_out, 32'h12345000);
      check_val("lui_type_const", 32'(imm_type), 32'd4);

      // Asynchronous reset mid-cycle, then reload from the current input
      #3 rst_n = 1'b0;
      #1;
      check_val("async_rst_imm",  data_out, 32'h0);
      check_val("async_rst_type", 32'(imm_type), 32'd0);
      @(negedge clk);
      data_in = 32'hFFF00093;
      #2 rst_n = 1'b1;
      sb.push_back(model(32'hFFF00093));
      @(posedge clk);
      #1;
      pop_check("post_reset");

      // SYSTEM csrrwi: zimm only with the optional feature
      drive(32'h0002D073, "csrrwi");
`ifdef IMM_ZICSR_EN
      check_val("csrrwi_const", data_out, 32'h00000005);
      check_val("csrrwi_type_const", 32'(imm_type), 32'd6);
`else
      check_val("csrrwi_const", data_out, 32'h00000000);
      check_val("csrrwi_type_const", 32'(imm_type), 32'd1);
`endif
      drive(32'h30002073, "csrrs");
      drive(32'h40105013, "srai");
      drive(32'h00000000, "zero_word");

      // Random words over the opcode set plus an illegal opcode
      for (int i = 0; i < 60; i++) begin
         w = $urandom;
         if (i % 6 != 5) w[6:0] = ops[$urandom_range(0, 9)];
         drive(w, "rand");
      end

      // Every pushed expectation must have been consumed
      check_val("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
